// File: rtl/timer_prescale_ctrl.sv
// timer_prescale_ctrl: prescaled tick-enable timer with compare match, one-shot/auto-reload and irq (optional capture via TIMER_CAPTURE_EN)
module timer_prescale_ctrl #(
  parameter int WIDTH   = 32,
  parameter int PS_BITS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
`ifdef TIMER_CAPTURE_EN
  input  logic        capture_in,
`endif
  output logic [31:0] rdata,
  output logic        irq,
  output logic        tick,
  output logic        running
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [PS_BITS-1:0] r_ps;
  logic               r_tap_d;
  logic               r_en;
  logic               r_auto;
  logic [4:0]         r_sel;
  logic               r_irq_en;
  logic [WIDTH-1:0]   r_compare;
  logic [WIDTH-1:0]   r_count;
  logic               r_match;
  logic [1:0]         r_state;

  logic        w_ctrl_wr;
  logic        w_cmp_wr;
  logic        w_cnt_wr;
  logic        w_sts_wr;
  logic        w_tap;
  logic        w_hit;
  logic        w_match;
  logic        w_cap_flag;
  logic [31:0] w_capture;

  assign w_ctrl_wr = wr_en && addr == 3'd0;
  assign w_cmp_wr  = wr_en && addr == 3'd1;
  assign w_cnt_wr  = wr_en && addr == 3'd2;
  assign w_sts_wr  = wr_en && addr == 3'd3;
  assign w_tap     = r_ps[r_sel];
  assign tick      = w_tap & ~r_tap_d & (r_state == S_RUN) & ~w_ctrl_wr;
  assign w_hit     = r_count == r_compare;
  assign w_match   = tick & w_hit;
  assign running   = r_state == S_RUN;
  assign irq       = (r_match | w_cap_flag) & r_irq_en;

  // free-running prescaler, restarted by every CTRL write so the first tick lands 2^sel cycles later
  always_ff @(posedge clk) begin
    if (rst || w_ctrl_wr) begin
      r_ps    <= '0;
      r_tap_d <= 1'b0;
    end else begin
      r_ps    <= r_ps + 1'b1;
      r_tap_d <= w_tap;
    end
  end

  // control fields and run state; a one-shot match drops enable and parks in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en     <= 1'b0;
      r_auto   <= 1'b0;
      r_sel    <= '0;
      r_irq_en <= 1'b0;
      r_state  <= S_IDLE;
    end else if (w_ctrl_wr) begin
      r_en     <= wdata[0];
      r_auto   <= wdata[1];
      r_sel    <= wdata[6:2];
      r_irq_en <= wdata[7];
      r_state  <= wdata[0] ? S_RUN : S_IDLE;
    end else if (w_match && !r_auto) begin
      r_en    <= 1'b0;
      r_state <= S_DONE;
    end
  end

  // compare register
  always_ff @(posedge clk) begin
    if (rst) r_compare <= '1;
    else if (w_cmp_wr) r_compare <= wdata[WIDTH-1:0];
  end

  // counter: a software load beats a simultaneous tick
  always_ff @(posedge clk) begin
    if (rst) r_count <= '0;
    else if (w_cnt_wr) r_count <= wdata[WIDTH-1:0];
    else if (tick) r_count <= w_hit ? (r_auto ? '0 : r_count) : r_count + 1'b1;
  end

  // match flag: a new match wins over a same-cycle write-1-to-clear
  always_ff @(posedge clk) begin
    if (rst) r_match <= 1'b0;
    else if (w_match) r_match <= 1'b1;
    else if (w_sts_wr && wdata[0]) r_match <= 1'b0;
  end

`ifdef TIMER_CAPTURE_EN
  logic [1:0]       r_cap_hist;
  logic [WIDTH-1:0] r_capture;
  logic             r_cap_flag;
  logic             w_cap_edge;

  assign w_cap_edge = r_cap_hist[0] & ~r_cap_hist[1];
  assign w_cap_flag = r_cap_flag;
  assign w_capture  = 32'(r_capture);

  // capture edge history; snapshot takes the pre-increment count, set wins over clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap_hist <= '0;
      r_capture  <= '0;
      r_cap_flag <= 1'b0;
    end else begin
      r_cap_hist <= {r_cap_hist[0], capture_in};
      if (w_cap_edge && r_state == S_RUN) begin
        r_capture  <= r_count;
        r_cap_flag <= 1'b1;
      end else if (w_sts_wr && wdata[1]) r_cap_flag <= 1'b0;
    end
  end
`else
  assign w_cap_flag = 1'b0;
  assign w_capture  = '0;
`endif

  assign rdata = addr == 3'd0 ? {24'd0, r_irq_en, r_sel, r_auto, r_en} :
                 addr == 3'd1 ? 32'(r_compare) :
                 addr == 3'd2 ? 32'(r_count) :
                 addr == 3'd3 ? {30'd0, w_cap_flag, r_match} :
                 addr == 3'd4 ? w_capture : '0;
endmodule
